// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation classes and the ALU control codes driven to the datapath.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
    JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's ALU operation class and the R-type funct
// field onto the 3-bit ALU control code.
module aludec
  import mips_pkg::*;
(
  input  logic    [5:0] funct_i,
  input  alu_op_t       alu_op_i,
  output logic    [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_AND;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: alu_control_o = ALU_AND;
        endcase
      end
      default: alu_control_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, memory,
// ALU and branch/jump steps, with a memory handshake stalling the memory states.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [2:0] alu_control
);

  state_t state_q, state_d;

  logic       memReqDec, iordDec, memWriteDec, irWriteDec;
  logic       regDstDec, memRegDec, regWriteDec, aluSrcADec;
  logic [1:0] aluSrcBDec, pcSrcDec;
  logic       pcWrite, branch, aluEn;
  alu_op_t    aluOp;
  logic [2:0] aluCtrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_SW)      state_d = MEMWR;
        else if (op == OP_LW) state_d = MEMRD;
        else                  state_d = FETCH;
      end
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWR:   if (mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // aluEn marks states that actually use the ALU; elsewhere alu_control reads 0.
  always_comb begin
    memReqDec   = 1'b0;
    iordDec     = 1'b0;
    memWriteDec = 1'b0;
    irWriteDec  = 1'b0;
    regDstDec   = 1'b0;
    memRegDec   = 1'b0;
    regWriteDec = 1'b0;
    aluSrcADec  = 1'b0;
    aluSrcBDec  = 2'b00;
    pcSrcDec    = 2'b00;
    pcWrite     = 1'b0;
    branch      = 1'b0;
    aluEn       = 1'b0;
    aluOp       = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        memReqDec  = 1'b1;
        aluSrcBDec = 2'b01;
        aluEn      = 1'b1;
        irWriteDec = mem_ready;
        pcWrite    = mem_ready;
      end
      DECODE: begin
        aluSrcBDec = 2'b11;
        aluEn      = 1'b1;
      end
      MEMADR, ADDIEX: begin
        aluSrcADec = 1'b1;
        aluSrcBDec = 2'b10;
        aluEn      = 1'b1;
      end
      MEMRD: begin
        memReqDec = 1'b1;
        iordDec   = 1'b1;
      end
      MEMWB: begin
        regWriteDec = 1'b1;
        memRegDec   = 1'b1;
      end
      MEMWR: begin
        memReqDec   = 1'b1;
        iordDec     = 1'b1;
        memWriteDec = 1'b1;
      end
      EXECUTE: begin
        aluSrcADec = 1'b1;
        aluEn      = 1'b1;
        aluOp      = ALUOP_FUNCT;
      end
      ALUWB: begin
        regWriteDec = 1'b1;
        regDstDec   = 1'b1;
      end
      BRANCH: begin
        aluSrcADec = 1'b1;
        aluEn      = 1'b1;
        aluOp      = ALUOP_SUB;
        pcSrcDec   = 2'b01;
        branch     = 1'b1;
      end
      ADDIWB:  regWriteDec = 1'b1;
      JUMP: begin
        pcSrcDec = 2'b10;
        pcWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  aludec u_aludec (
    .funct_i       (funct),
    .alu_op_i      (aluOp),
    .alu_control_o (aluCtrl)
  );

  // Outputs are gated by reset_n so an abort silences every strobe at once.
  assign mem_req     = reset_n & memReqDec;
  assign iord        = reset_n & iordDec;
  assign mem_write   = reset_n & memWriteDec;
  assign ir_write    = reset_n & irWriteDec;
  assign reg_dst     = reset_n & regDstDec;
  assign mem_reg     = reset_n & memRegDec;
  assign reg_write   = reset_n & regWriteDec;
  assign alu_src_a   = reset_n & aluSrcADec;
  assign alu_src_b   = reset_n ? aluSrcBDec : 2'b00;
  assign pc_src      = reset_n ? pcSrcDec : 2'b00;
  assign pc_en       = reset_n & (pcWrite | (branch & zero));
  assign alu_control = (reset_n && aluEn) ? aluCtrl : 3'b000;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, corner
// sequences and random instruction streams against a per-cycle reference model.
module tb_multicycle_controller;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, memReady = 1'b0;
  logic       memReq, iord, memWrite, irWrite, regDst, memReg, regWrite, aluSrcA, pcEn;
  logic [1:0] aluSrcB, pcSrc;
  logic [2:0] aluControl;
  logic [15:0] dutVec;

  int testsRun = 0;
  int testsFailed = 0;
  int wrSeen, rwSeen;

  logic        modelReady[$];
  logic [15:0] modelExp[$];
  string       modelTag[$];

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         lat;
    logic [2:0] expAlu;
    logic       expPcEn;
  } vec_t;
  vec_t vecs[$];

  multicycle_controller dut (
    .clk(clk), .reset_n(resetN), .op(op), .funct(funct), .zero(zero),
    .mem_ready(memReady), .mem_req(memReq), .iord(iord), .mem_write(memWrite),
    .ir_write(irWrite), .reg_dst(regDst), .mem_reg(memReg), .reg_write(regWrite),
    .alu_src_a(aluSrcA), .alu_src_b(aluSrcB), .pc_src(pcSrc), .pc_en(pcEn),
    .alu_control(aluControl)
  );

  always #5 clk = ~clk;

  assign dutVec = {memReq, iord, memWrite, irWrite, regDst, memReg, regWrite,
                   aluSrcA, aluSrcB, pcSrc, pcEn, aluControl};

  function automatic logic [15:0] mk(logic req, logic io, logic wr, logic ir, logic dst,
                                     logic mr, logic rw, logic sa, logic [1:0] sb,
                                     logic [1:0] ps, logic pe, logic [2:0] alu);
    return {req, io, wr, ir, dst, mr, rw, sa, sb, ps, pe, alu};
  endfunction

  function automatic logic [2:0] refAlu(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] expFetch(logic r);
    return mk(1, 0, 0, r, 0, 0, 0, 0, 2'b01, 2'b00, r, 3'b010);
  endfunction
  function automatic logic [15:0] expDecode();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010);
  endfunction
  function automatic logic [15:0] expAddrCalc();
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010);
  endfunction
  function automatic logic [15:0] expMemRd();
    return mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000);
  endfunction
  function automatic logic [15:0] expMemWr();
    return mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000);
  endfunction
  function automatic logic [15:0] expWriteBack(logic dst, logic mr);
    return mk(0, 0, 0, 0, dst, mr, 1, 0, 2'b00, 2'b00, 0, 3'b000);
  endfunction
  function automatic logic [15:0] expExec(logic [5:0] f);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, refAlu(f));
  endfunction
  function automatic logic [15:0] expBranch(logic z);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, z, 3'b110);
  endfunction
  function automatic logic [15:0] expJump();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 3'b000);
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic fetchLike();
    return memReq && !iord && !memWrite && (aluSrcB == 2'b01);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pushCycle(input string tag, input logic rdy, input logic [15:0] e);
    modelTag.push_back(tag);
    modelReady.push_back(rdy);
    modelExp.push_back(e);
  endtask

  // Reference model: the expected per-cycle output sequence of one instruction.
  task automatic buildModel(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fw, input int mw);
    for (int i = 0; i < fw; i++) pushCycle("fetch wait", 1'b0, expFetch(1'b0));
    pushCycle("fetch", 1'b1, expFetch(1'b1));
    pushCycle("decode", rnd(), expDecode());
    if (o == OP_LW) begin
      pushCycle("memadr", rnd(), expAddrCalc());
      for (int i = 0; i < mw; i++) pushCycle("memrd wait", 1'b0, expMemRd());
      pushCycle("memrd", 1'b1, expMemRd());
      pushCycle("memwb", rnd(), expWriteBack(1'b0, 1'b1));
    end else if (o == OP_SW) begin
      pushCycle("memadr", rnd(), expAddrCalc());
      for (int i = 0; i < mw; i++) pushCycle("memwr wait", 1'b0, expMemWr());
      pushCycle("memwr", 1'b1, expMemWr());
    end else if (o == OP_R) begin
      pushCycle("execute", rnd(), expExec(f));
      pushCycle("aluwb", rnd(), expWriteBack(1'b1, 1'b0));
    end else if (o == OP_BEQ) begin
      pushCycle("branch", rnd(), expBranch(z));
    end else if (o == OP_ADDI) begin
      pushCycle("addiex", rnd(), expAddrCalc());
      pushCycle("addiwb", rnd(), expWriteBack(1'b0, 1'b0));
    end else if (o == OP_J) begin
      pushCycle("jump", rnd(), expJump());
    end
  endtask

  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input int fw, input int mw);
    buildModel(o, f, z, fw, mw);
    op = o; funct = f; zero = z;
    wrSeen = 0; rwSeen = 0;
    while (modelExp.size() > 0) begin
      memReady = modelReady.pop_front();
      @(negedge clk);
      if (memWrite) wrSeen++;
      if (regWrite) rwSeen++;
      checkOutput(modelTag.pop_front(), dutVec, modelExp.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic addVec(input string n, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input int lat, input logic [2:0] a, input logic pe);
    vec_t v;
    v.name = n; v.op = o; v.funct = f; v.zero = z;
    v.lat = lat; v.expAlu = a; v.expPcEn = pe;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] fList[6];
    logic [5:0] ro, rf;
    int cls;
    fList = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    addVec("R add",    OP_R,    6'b100000, 1'b0, 4, 3'b010, 1'b0);
    addVec("R sub",    OP_R,    6'b100010, 1'b0, 4, 3'b110, 1'b0);
    addVec("R and",    OP_R,    6'b100100, 1'b0, 4, 3'b000, 1'b0);
    addVec("R or",     OP_R,    6'b100101, 1'b0, 4, 3'b001, 1'b0);
    addVec("R slt",    OP_R,    6'b101010, 1'b0, 4, 3'b111, 1'b0);
    addVec("R other",  OP_R,    6'b000000, 1'b1, 4, 3'b000, 1'b0);
    addVec("beq z1",   OP_BEQ,  6'b000000, 1'b1, 3, 3'b110, 1'b1);
    addVec("beq z0",   OP_BEQ,  6'b100000, 1'b0, 3, 3'b110, 1'b0);
    addVec("j",        OP_J,    6'b000000, 1'b0, 3, 3'b000, 1'b1);
    addVec("addi",     OP_ADDI, 6'b100010, 1'b0, 4, 3'b010, 1'b0);
    addVec("lw",       OP_LW,   6'b000000, 1'b0, 5, 3'b010, 1'b0);
    addVec("sw",       OP_SW,   6'b000000, 1'b1, 4, 3'b010, 1'b0);

    // Reset: outputs silent even though FETCH with mem_ready=1 would strobe.
    resetN = 1'b0; memReady = 1'b1;
    @(negedge clk);
    checkOutput("reset outputs", dutVec, 16'h0000);
    @(posedge clk); #1;
    resetN = 1'b1; memReady = 1'b0;
    @(negedge clk);
    checkOutput("first fetch after reset", dutVec, expFetch(1'b0));
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      memReady = 1'b1; op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
      for (int c = 1; c <= vecs[i].lat; c++) begin
        @(negedge clk);
        if (c == 3) begin
          checkOutput({vecs[i].name, " alu_control"}, 16'(aluControl), 16'(vecs[i].expAlu));
          checkOutput({vecs[i].name, " pc_en"}, 16'(pcEn), 16'(vecs[i].expPcEn));
        end
        if (c == vecs[i].lat)
          checkOutput({vecs[i].name, " still busy"}, 16'(fetchLike()), 16'(0));
        @(posedge clk); #1;
      end
      checkOutput({vecs[i].name, " back in fetch"}, 16'(fetchLike()), 16'(1));
    end

    applyStimulus(OP_LW, 6'b000000, 1'b0, 0, 0);
    checkOutput("lw reg_write cycles", 16'(rwSeen), 16'(1));
    applyStimulus(OP_SW, 6'b000000, 1'b0, 0, 3);
    checkOutput("sw mem_write cycles", 16'(wrSeen), 16'(4));
    applyStimulus(6'b111111, 6'b000000, 1'b0, 0, 0);
    checkOutput("undef reg_write", 16'(rwSeen), 16'(0));
    checkOutput("undef mem_write", 16'(wrSeen), 16'(0));

    // Reset while lw waits in MEMRD: abort with no writeback afterwards.
    memReady = 1'b1; op = OP_LW; funct = '0;
    repeat (3) begin @(posedge clk); #1; end
    memReady = 1'b0;
    @(negedge clk);
    checkOutput("memrd wait 1", dutVec, expMemRd());
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("memrd wait 2", dutVec, expMemRd());
    resetN = 1'b0; memReady = 1'b1;
    #1;
    checkOutput("reset during memrd", dutVec, 16'h0000);
    @(posedge clk); #1;
    checkOutput("reset held", dutVec, 16'h0000);
    memReady = 1'b0; resetN = 1'b1;
    @(negedge clk);
    checkOutput("fetch after abort", dutVec, expFetch(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("no writeback after abort", dutVec, expFetch(1'b0));
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      cls = int'($urandom_range(0, 6));
      case (cls)
        0: ro = OP_R;
        1: ro = OP_LW;
        2: ro = OP_SW;
        3: ro = OP_BEQ;
        4: ro = OP_ADDI;
        5: ro = OP_J;
        default: begin
          ro = 6'($urandom_range(0, 63));
          while (ro == OP_R || ro == OP_LW || ro == OP_SW || ro == OP_BEQ ||
                 ro == OP_ADDI || ro == OP_J)
            ro = 6'($urandom_range(0, 63));
        end
      endcase
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                       : fList[$urandom_range(0, 5)];
      applyStimulus(ro, rf, rnd(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instruction opcode field, taken from the instruction register.
REQ-005 funct  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completion handshake; 1 = access completes this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 iord  output  1  address mux select; 0 = PC, 1 = ALUOut.
REQ-010 mem_write  output  1  memory write strobe.
REQ-011 ir_write  output  1  instruction register load enable.
REQ-012 reg_dst  output  1  register destination select; 1 = rd, 0 = rt.
REQ-013 mem_reg  output  1  writeback select; 1 = memory data, 0 = ALUOut.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 alu_src_a  output  1  ALU A select; 0 = PC, 1 = register A.
REQ-016 alu_src_b  output  2  ALU B select; 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-017 pc_src  output  2  next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 pc_en  output  1  PC load enable.
REQ-019 alu_control  output  3  ALU operation code.

Function
REQ-020 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB and JUMP.
REQ-021 Opcode decoding SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-022 Transitions SHALL be as follows:
- FETCH -> DECODE when mem_ready=1, otherwise hold in FETCH.
- DECODE -> MEMADR on lw or sw, EXECUTE on R-type, BRANCH on beq, ADDIEX on addi, JUMP on j.
- DECODE -> FETCH on any other opcode (treated as a no-op).
- MEMADR -> MEMRD on lw, MEMWR on sw.
- MEMRD -> MEMWB when mem_ready=1, otherwise hold.
- MEMWR -> FETCH when mem_ready=1, otherwise hold.
- EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
REQ-023 Any output not listed for a state SHALL be 0 in that state.
REQ-024 Per-state outputs SHALL be:
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, ALU add; ir_write=1 and pc_write=1 only in cycles where mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, ALU add.
- MEMADR: alu_src_a=1, alu_src_b=10, ALU add.
- MEMRD: mem_req=1, iord=1.
- MEMWB: reg_write=1, mem_reg=1, reg_dst=0.
- MEMWR: mem_req=1, iord=1, mem_write=1.
- EXECUTE: alu_src_a=1, alu_src_b=00, ALU from funct.
- ALUWB: reg_write=1, reg_dst=1, mem_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, ALU sub, pc_src=01, branch=1.
- ADDIEX: alu_src_a=1, alu_src_b=10, ALU add.
- ADDIWB: reg_write=1, reg_dst=0, mem_reg=0.
- JUMP: pc_src=10, pc_write=1.
REQ-025 pc_en SHALL equal pc_write OR (branch AND zero), evaluated combinationally in the same cycle.
REQ-026 The internal ALU operation (alu_op) SHALL be 00 for add, 01 for sub and 10 for decode-from-funct.
REQ-027 alu_control SHALL be 010 for add (alu_op 00) and 110 for sub (alu_op 01).
REQ-028 For alu_op 10, alu_control SHALL decode funct as: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 000.
REQ-029 Instruction latencies with mem_ready tied to 1 SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, undefined opcode 2.
REQ-030 Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle, with that state's outputs held stable.
REQ-031 mem_ready SHALL be ignored in all other states.

Reset
REQ-032 While reset_n=0, the state SHALL be FETCH and every output SHALL be 0, including mem_req, ir_write, pc_en, mem_write and reg_write.
REQ-033 Asserting reset_n=0 mid-instruction, including during a mem_ready wait, SHALL abort the instruction immediately with no partial writeback.
REQ-034 After reset_n rises, the first active edge SHALL evaluate FETCH.

Structure
REQ-035 Package mips_pkg SHALL hold the state enum, the opcode constants, the alu_op encodings and the alu_control codes.
REQ-036 The ALU decode SHALL be a single sub-module, aludec (funct, alu_op -> alu_control), instantiated once.
REQ-037 The FSM SHALL use one state register with a combinational next-state block and a combinational output decode.

Verification
REQ-038 lw (op=100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 with mem_reg=1 in cycle 5 only.
REQ-039 sw with mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 for 4 cycles, then FETCH.
REQ-040 beq with zero=1 -> pc_en=1 in BRANCH; with zero=0 -> pc_en=0; alu_control=110 in both cases.
REQ-041 R-type sweep of funct 100000, 100010, 100100, 100101, 101010, 000000 -> alu_control 010, 110, 000, 001, 111, 000 in EXECUTE.
REQ-042 reset_n=0 asserted during a MEMRD wait -> all outputs 0 immediately; FETCH on release, with no reg_write pulse.
REQ-043 op=111111 -> DECODE -> FETCH in 2 cycles; no reg_write and no mem_write.
